// File: rtl/ysyx_23060191_ifu_hs.sv
// Multi-cycle instruction fetch stage: PC in, one AR/R read to instruction memory, instruction out.
// Optional WAIT_R watchdog enabled by defining IFU_TIMEOUT_EN.
module ysyx_23060191_ifu_hs #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rstn,
  // next PC from PCU
  input  logic [31:0] pc_in,
  input  logic        pc_in_valid,
  output logic        pc_in_ready,
  // instruction memory read bus
  output logic [31:0] ar_addr,
  output logic        ar_valid,
  input  logic        ar_ready,
  input  logic [31:0] r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_valid,
  output logic        r_ready,
  // instruction to IDU
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_HOLD
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  state_e      state_q, state_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        fetch_err_q, fetch_err_d;
  logic        r_timeout;

`ifdef IFU_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  // Held at zero outside WAIT_R, so it is already clear on entry.
  always_comb begin
    wait_cnt_d = '0;
    r_timeout  = 1'b0;
    if (state_q == S_WAIT_R && !r_valid) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
      r_timeout  = (wait_cnt_d == TIMEOUT_LIM);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_timeout_cyc;

  assign r_timeout          = 1'b0;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  // NOTE: every always_comb output gets a default before the case; a missed
  // branch would otherwise hold its old value and infer a latch.
  always_comb begin
    state_d     = state_q;
    ar_addr_d   = ar_addr_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    fetch_err_d = fetch_err_q;

    unique case (state_q)
      S_BOOT: begin
        ar_addr_d = RESET_PC;
        state_d   = S_REQ;
      end

      S_IDLE: begin
        if (pc_in_valid) begin
          if (pc_in[1:0] == 2'b00) begin
            ar_addr_d = pc_in;
            state_d   = S_REQ;
          end else begin
            // Misaligned PC never reaches the bus.
            inst_d      = NOP_INST;
            inst_pc_d   = pc_in;
            fetch_err_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
      end

      S_REQ: begin
        if (ar_ready) begin
          state_d = S_WAIT_R;
        end
      end

      S_WAIT_R: begin
        // A response arriving on the timeout cycle still completes normally.
        if (r_valid) begin
          inst_pc_d = ar_addr_q;
          state_d   = S_HOLD;
          if (r_resp == RESP_OKAY) begin
            inst_d      = r_data;
            fetch_err_d = 1'b0;
          end else begin
            inst_d      = NOP_INST;
            fetch_err_d = 1'b1;
          end
        end else if (r_timeout) begin
          inst_d      = NOP_INST;
          inst_pc_d   = ar_addr_q;
          fetch_err_d = 1'b1;
          state_d     = S_HOLD;
        end
      end

      S_HOLD: begin
        if (inst_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: datapath registers are reset too, since the IDU-facing and bus-facing
      // values are observable right after reset and must be defined.
      state_q     <= S_BOOT;
      ar_addr_q   <= RESET_PC;
      inst_q      <= NOP_INST;
      inst_pc_q   <= RESET_PC;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ar_addr_q   <= ar_addr_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign pc_in_ready = (state_q == S_IDLE);
  assign ar_valid    = (state_q == S_REQ);
  assign r_ready     = (state_q == S_WAIT_R);
  assign inst_valid  = (state_q == S_HOLD);

  assign ar_addr   = ar_addr_q;
  assign inst      = inst_q;
  assign inst_pc   = inst_pc_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ysyx_23060191_ifu_hs.sv
// Scoreboard bench for ysyx_23060191_ifu_hs: directed fetches against a configurable memory model.
// The watchdog fetch is exercised only when IFU_TIMEOUT_EN is defined.
module tb_ysyx_23060191_ifu_hs;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int          TO_CYC   = 8;
  localparam int          BOUND    = 400;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [31:0] pc_in;
  logic        pc_in_valid;
  logic        pc_in_ready;
  logic [31:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  // memory model configuration, set by the stimulus before each fetch
  logic [31:0] mem_data   = 32'h0;
  logic [1:0]  mem_resp   = 2'b00;
  int          mem_ar_dly = 0;
  int          mem_r_dly  = 0;
  bit          mem_silent = 1'b0;

  ysyx_23060191_ifu_hs #(
    .RESET_PC   (RESET_PC),
    .NOP_INST   (NOP_INST),
    .TIMEOUT_CYC(TO_CYC)
  ) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .pc_in      (pc_in),
    .pc_in_valid(pc_in_valid),
    .pc_in_ready(pc_in_ready),
    .ar_addr    (ar_addr),
    .ar_valid   (ar_valid),
    .ar_ready   (ar_ready),
    .r_data     (r_data),
    .r_resp     (r_resp),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: accepts AR after mem_ar_dly stalled cycles, returns R mem_r_dly cycles later.
  initial begin : mem_model
    int phase;
    int cnt;
    phase    = 0;
    cnt      = 0;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    r_data   = 32'h0;
    r_resp   = 2'b00;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        phase    = 0;
        cnt      = 0;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
      end else begin
        case (phase)
          0: begin
            if (ar_valid) begin
              if (cnt == mem_ar_dly) begin
                ar_ready = 1'b1;
                phase    = 1;
                cnt      = 0;
              end else begin
                cnt++;
              end
            end
          end
          1: begin
            ar_ready = 1'b0;
            if (!r_ready) begin
              phase = 0;
              cnt   = 0;
            end else if (!mem_silent) begin
              if (cnt == mem_r_dly) begin
                r_valid = 1'b1;
                r_data  = mem_data;
                r_resp  = mem_resp;
                phase   = 2;
              end else begin
                cnt++;
              end
            end
          end
          default: begin
            r_valid = 1'b0;
            r_data  = 32'h0;
            r_resp  = 2'b00;
            phase   = 0;
            cnt     = 0;
          end
        endcase
      end
    end
  end

  // Monitor: every IDU handshake pops one expected instruction.
  initial begin : sb_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rstn && inst_valid && inst_ready) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("sb_inst", inst, e.inst);
          check("sb_inst_pc", inst_pc, e.pc);
          check("sb_fetch_err", 32'(fetch_err), 32'(e.err));
        end
      end
    end
  end

  // Called on the first negedge after the request was taken.
  task automatic wait_inst(input exp_t e, input int exp_lat, input int exp_arc,
                           input logic [31:0] exp_addr, input int idu);
    int lat = 1;
    int arc = 0;
    while (!inst_valid && lat < BOUND) begin
      check("busy_pc_in_ready", 32'(pc_in_ready), 32'd0);
      if (ar_valid) begin
        arc++;
        check("ar_addr_stable", ar_addr, exp_addr);
      end
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("ar_valid_cycles", 32'(arc), 32'(exp_arc));
    for (int i = 0; i <= idu; i++) begin
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_inst", inst, e.inst);
      check("hold_inst_pc", inst_pc, e.pc);
      check("hold_fetch_err", 32'(fetch_err), 32'(e.err));
      check("hold_pc_in_ready", 32'(pc_in_ready), 32'd0);
      if (i == idu) inst_ready = 1'b1;
      @(negedge clk);
    end
    inst_ready = 1'b0;
    check("idle_pc_in_ready", 32'(pc_in_ready), 32'd1);
    check("idle_inst_valid", 32'(inst_valid), 32'd0);
  endtask

  task automatic reset_and_boot(input logic [31:0] data);
    exp_t e;
    rstn = 1'b0;
    #1;
    check("rst_ar_valid", 32'(ar_valid), 32'd0);
    check("rst_r_ready", 32'(r_ready), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_pc_in_ready", 32'(pc_in_ready), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_ar_addr", ar_addr, RESET_PC);
    check("rst_inst_pc", inst_pc, RESET_PC);
    check("rst_inst", inst, NOP_INST);
    mem_data   = data;
    mem_resp   = 2'b00;
    mem_ar_dly = 0;
    mem_r_dly  = 0;
    mem_silent = 1'b0;
    e.inst = data;
    e.pc   = RESET_PC;
    e.err  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb_q.push_back(e);
    rstn = 1'b1;
    @(negedge clk);
    wait_inst(e, 3, 1, RESET_PC, 0);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input logic [1:0] resp,
                       input int ard, input int rd, input bit silent, input int idu);
    exp_t e;
    bit   mis;
    int   lat;
    int   w;
    mis    = (pc[1:0] != 2'b00);
    e.err  = mis || silent || (resp != 2'b00);
    e.inst = e.err ? NOP_INST : data;
    e.pc   = pc;
    lat    = mis ? 1 : (silent ? 2 + TO_CYC : 3 + ard + rd);
    mem_data   = data;
    mem_resp   = resp;
    mem_ar_dly = ard;
    mem_r_dly  = rd;
    mem_silent = silent;
    w = 0;
    while (!pc_in_ready && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    check("pc_in_ready_idle", 32'(pc_in_ready), 32'd1);
    sb_q.push_back(e);
    pc_in       = pc;
    pc_in_valid = 1'b1;
    @(negedge clk);
    pc_in_valid = 1'b0;
    pc_in       = 32'h0;
    wait_inst(e, lat, mis ? 0 : 1 + ard, pc, idu);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int w;
    rstn        = 1'b0;
    pc_in       = 32'h0;
    pc_in_valid = 1'b0;
    inst_ready  = 1'b0;
    @(negedge clk);

    // boot fetch from RESET_PC
    reset_and_boot(32'h0000_0297);
    // zero-wait fetch, 3-cycle latency
    fetch(32'h8000_0004, 32'h0041_0113, 2'b00, 0, 0, 1'b0, 0);
    // AR stalled 5 cycles, IDU stalled 4 cycles
    fetch(32'h8000_0008, 32'h00a5_8593, 2'b00, 5, 0, 1'b0, 4);
    // error response, then a normal fetch with slow R
    fetch(32'h8000_000c, 32'hdead_beef, 2'b10, 0, 0, 1'b0, 0);
    fetch(32'h8000_0010, 32'h0010_0073, 2'b00, 0, 2, 1'b0, 1);
    // misaligned PCs: no bus access
    fetch(32'h8000_0006, 32'h1234_5678, 2'b00, 0, 0, 1'b0, 0);
    fetch(32'h8000_0001, 32'h1234_5678, 2'b00, 0, 0, 1'b0, 2);
    // top-of-space PC used as-is, SLVERR-free but delayed
    fetch(32'hffff_fffc, 32'h0000_0513, 2'b00, 1, 1, 1'b0, 0);
    fetch(32'h0000_0000, 32'h0000_0000, 2'b11, 0, 0, 1'b0, 0);
`ifdef IFU_TIMEOUT_EN
    // memory never answers: watchdog completes with a NOP
    fetch(32'h8000_0020, 32'hffff_ffff, 2'b00, 0, 0, 1'b1, 0);
    fetch(32'h8000_0024, 32'h0000_0093, 2'b00, 0, 0, 1'b0, 0);
`endif

    // reset asserted while waiting for R
    mem_silent = 1'b1;
    w = 0;
    while (!pc_in_ready && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    pc_in       = 32'h8000_0100;
    pc_in_valid = 1'b1;
    @(negedge clk);
    pc_in_valid = 1'b0;
    w = 0;
    while (!r_ready && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    check("abort_in_wait_r", 32'(r_ready), 32'd1);
    #2;
    reset_and_boot(32'h0000_0517);
    fetch(32'h8000_0004, 32'h0000_0593, 2'b00, 0, 0, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
